// File: rtl/au_cmd_sequencer.sv
// Command FIFO and issue/settle/capture sequencer in front of the 4-bit arithmetic unit.
// Optional overflow error counter enabled by defining AU_ERR_COUNT_EN.
module au_cmd_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [1:0] cmd_op,
  output logic [3:0] au_a,
  output logic [3:0] au_b,
  output logic [1:0] au_op,
  input  logic [7:0] au_result,
  input  logic       au_zero,
  input  logic       au_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_overflow,
  output logic [1:0] rsp_op,
`ifdef AU_ERR_COUNT_EN
  input  logic       err_clr,
  output logic [7:0] err_count,
`endif
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt    = CW'(DEPTH);
  localparam logic [3:0]    SettleLoad = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  state_e          state_q, state_d;
  logic [9:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [3:0]      cnt_q, cnt_d;
  logic            full, empty, push, pop, capture;
  logic [3:0]      au_a_q, au_b_q;
  logic [1:0]      au_op_q;
  logic            rsp_valid_q;
  logic [7:0]      rsp_result_q;
  logic            rsp_zero_q, rsp_overflow_q;
  logic [1:0]      rsp_op_q;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = SettleLoad;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            cnt_d   = SettleLoad;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      au_a_q         <= '0;
      au_b_q         <= '0;
      au_op_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_op_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        {au_op_q, au_b_q, au_a_q} <= mem_q[rd_ptr_q];
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (capture) begin
        rsp_valid_q    <= 1'b1;
        rsp_result_q   <= au_result;
        rsp_zero_q     <= au_zero;
        rsp_overflow_q <= au_overflow;
        rsp_op_q       <= au_op_q;
      end else if (state_q == StHold && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef AU_ERR_COUNT_EN
  logic [7:0] err_count_q;

  // Clear wins over a same-edge increment; the count saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (err_clr) begin
      err_count_q <= '0;
    end else if (capture && au_overflow && err_count_q != 8'hFF) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

  assign au_a         = au_a_q;
  assign au_b         = au_b_q;
  assign au_op        = au_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_op       = rsp_op_q;
  assign busy         = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_au_cmd_sequencer.sv
// Scoreboard bench for au_cmd_sequencer with a behavioural arithmetic unit model.
// Exercises the error counter too when AU_ERR_COUNT_EN is defined.
module tb_au_cmd_sequencer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic [3:0] au_a, au_b;
  logic [1:0] au_op;
  logic [7:0] au_result;
  logic       au_zero, au_overflow;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_overflow;
  logic [1:0] rsp_op;
  logic       busy;
`ifdef AU_ERR_COUNT_EN
  logic       err_clr = 1'b0;
  logic [7:0] err_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] r;
    logic       z;
    logic       o;
  } vec_t;

  // Hand-computed expectations: add, sub (borrow => overflow), mul, div (b=0 => FF, overflow).
  vec_t vecs [8] = '{
    '{4'd3,  4'd5,  2'b00, 8'h08, 1'b0, 1'b0},
    '{4'd2,  4'd5,  2'b01, 8'hFD, 1'b0, 1'b1},
    '{4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 1'b0},
    '{4'd0,  4'd0,  2'b00, 8'h00, 1'b1, 1'b0},
    '{4'd9,  4'd0,  2'b11, 8'hFF, 1'b0, 1'b1},
    '{4'd9,  4'd2,  2'b11, 8'h04, 1'b0, 1'b0},
    '{4'd7,  4'd7,  2'b01, 8'h00, 1'b1, 1'b0},
    '{4'd3,  4'd4,  2'b10, 8'h0C, 1'b0, 1'b0}
  };

  logic [11:0] sb [$];
  int          hs_cycles [$];
  logic [11:0] exp_cur = '0;

  au_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .au_a         (au_a),
    .au_b         (au_b),
    .au_op        (au_op),
    .au_result    (au_result),
    .au_zero      (au_zero),
    .au_overflow  (au_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_op       (rsp_op),
`ifdef AU_ERR_COUNT_EN
    .err_clr      (err_clr),
    .err_count    (err_count),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural arithmetic unit.
  always_comb begin
    au_result   = 8'h00;
    au_overflow = 1'b0;
    case (au_op)
      2'b00: au_result = {4'b0, au_a} + {4'b0, au_b};
      2'b01: begin
        au_result   = {4'b0, au_a} - {4'b0, au_b};
        au_overflow = au_a < au_b;
      end
      2'b10: au_result = {4'b0, au_a} * {4'b0, au_b};
      default: begin
        if (au_b == 4'd0) begin
          au_result   = 8'hFF;
          au_overflow = 1'b1;
        end else begin
          au_result = {4'b0, au_a / au_b};
        end
      end
    endcase
    au_zero = (au_result == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Input monitor: record the expected response for every accepted command.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) sb.push_back(exp_cur);
  end

  // Output monitor: compare every delivered response against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      hs_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'(1'b0));
      end else begin
        chk("rsp", 32'({rsp_result, rsp_zero, rsp_overflow, rsp_op}), 32'(sb.pop_front()));
      end
    end
  end

  // Present a command at posedge+1 and hold it until accepted.
  task automatic send(input vec_t v);
    logic rdy;
    int   n = 0;
    cmd_a     = v.a;
    cmd_b     = v.b;
    cmd_op    = v.op;
    exp_cur   = {v.r, v.z, v.o, v.op};
    cmd_valid = 1'b1;
    do begin
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    cmd_valid = 1'b0;
    if (!rdy) chk("send_timeout", 32'(rdy), 32'(1'b1));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    int   acc;
    logic stale;
    vec_t v;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1'b1));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_au", 32'({au_a, au_b, au_op}), 32'(0));
    chk("rst_rsp", 32'({rsp_result, rsp_zero, rsp_overflow, rsp_op}), 32'(0));
`ifdef AU_ERR_COUNT_EN
    chk("rst_err_count", 32'(err_count), 32'(0));
`endif

    // Single add: accepted at edge 0, popped at edge 1, valid from edge 1+SETTLE.
    rsp_ready = 1'b1;
    send(vecs[0]);
    chk("lat_e0_valid", 32'(rsp_valid), 32'(1'b0));
    chk("lat_e0_busy", 32'(busy), 32'(1'b1));
    @(posedge clk);
    #1;
    chk("lat_e1_au", 32'({au_a, au_b, au_op}), 32'({4'd3, 4'd5, 2'b00}));
    chk("lat_e1_valid", 32'(rsp_valid), 32'(1'b0));
    @(posedge clk);
    #1;
    chk("lat_e2_valid", 32'(rsp_valid), 32'(1'b1));
    drain();

    // Directed vectors back-to-back.
    for (int i = 1; i < 8; i++) send(vecs[i]);
    drain();
`ifdef AU_ERR_COUNT_EN
    chk("err_count_after_vecs", 32'(err_count), 32'(2));
`endif

    // Fill with responses stalled: six offered, five accepted.
    rsp_ready = 1'b0;
    acc = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v       = vecs[i + 1];
      cmd_a   = v.a;
      cmd_b   = v.b;
      cmd_op  = v.op;
      exp_cur = {v.r, v.z, v.o, v.op};
      if (cmd_ready) acc++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("fill_accepted", 32'(acc), 32'(5));
    repeat (3) @(posedge clk);
    #1;
    chk("fill_ready_low", 32'(cmd_ready), 32'(1'b0));
    chk("fill_hold_valid", 32'(rsp_valid), 32'(1'b1));
    hs_cycles.delete();
    rsp_ready = 1'b1;
    chk("pop_cycle_ready_low", 32'(cmd_ready), 32'(1'b0));
    @(posedge clk);
    #1;
    chk("ready_after_pop", 32'(cmd_ready), 32'(1'b1));
    drain();
    chk("drain_count", 32'(hs_cycles.size()), 32'(5));
    for (int i = 1; i < hs_cycles.size(); i++)
      chk("drain_spacing", 32'(hs_cycles[i] - hs_cycles[i-1]), 32'(SETTLE + 1));

    // Reset while holding a response with three commands buffered.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vecs[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(rsp_valid), 32'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_valid", 32'(rsp_valid), 32'(1'b0));
    chk("mid_rst_ready", 32'(cmd_ready), 32'(1'b1));
    chk("mid_rst_busy", 32'(busy), 32'(1'b0));
    chk("mid_rst_au", 32'({au_a, au_b, au_op}), 32'(0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    stale     = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) stale = 1'b1;
    end
    chk("no_stale_after_rst", 32'(stale), 32'(1'b0));

`ifdef AU_ERR_COUNT_EN
    chk("err_count_after_rst", 32'(err_count), 32'(0));
    send(vecs[4]);
    drain();
    chk("err_count_div0", 32'(err_count), 32'(1));
    for (int i = 0; i < 255; i++) send(vecs[1]);
    drain();
    chk("err_count_sat", 32'(err_count), 32'(255));
    err_clr = 1'b1;
    send(vecs[1]);
    drain();
    err_clr = 1'b0;
    chk("err_clr_priority", 32'(err_count), 32'(0));
`endif

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d expected %0d", cyc, 0);
    $fatal(1);
  end

endmodule
